watch_ctrl_fsm: RTL

Control unit between the debounced button front end and the stopwatch/clock counters.
- Stopwatch mode (sw_mode=0): decodes run and clear presses into a run level and a clear pulse.
- Clock-set mode (sw_mode=1): turns sec/min/hour presses into single-cycle increment pulses, with hold-to-auto-repeat.
- Sits directly upstream of the stopwatch and clock datapaths. All outputs are registered.

---
 rtl/watch_ctrl_fsm.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/watch_ctrl_fsm.sv
// Button decode for the stopwatch (run level, clear pulse) and clock set (inc pulses); registered outputs one edge after a rise.
// WATCH_AUTO_REPEAT_EN adds hold-to-auto-repeat of set pulses; otherwise each set press yields exactly one pulse.
module watch_ctrl_fsm #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int CNT_W         = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_mode,
  input  logic       btn_run,
  input  logic       btn_clear,
  input  logic       btn_sec,
  input  logic       btn_min,
  input  logic       btn_hour,
  output logic       sw_run,
  output logic       sw_clear,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       inc_hour,
  output logic [1:0] sw_state
);

  typedef enum logic [1:0] {SW_STOP = 2'b00, SW_RUN = 2'b01, SW_CLEAR = 2'b10} sw_state_e;

`ifdef WATCH_AUTO_REPEAT_EN
  typedef enum logic [1:0] {SET_IDLE, SET_HOLD, SET_REPEAT} set_state_e;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  typedef enum logic {SET_IDLE, SET_WAIT_RELEASE} set_state_e;
  localparam int cfg_unused = HOLD_CYCLES + REPEAT_CYCLES + CNT_W;
`endif

  logic [4:0] btn_vec, prev_q, rise;
  logic [2:0] set_rise, pick, owner_q, owner_d, inc_q, inc_d;
  logic       owner_held;
  logic       sw_run_q, sw_run_d, sw_clear_q, sw_clear_d;
  sw_state_e  sw_state_q, sw_state_d;
  set_state_e set_state_q, set_state_d;

  // History runs in both modes so a button held across a mode switch needs a fresh press.
  assign btn_vec    = {btn_hour, btn_min, btn_sec, btn_clear, btn_run};
  assign rise       = btn_vec & ~prev_q;
  assign set_rise   = rise[4:2];
  assign pick       = set_rise[2] ? 3'b100 : (set_rise[1] ? 3'b010 : 3'b001);
  assign owner_held = |(owner_q & btn_vec[4:2]);

  always_comb begin
    sw_state_d = sw_state_q;
    unique case (sw_state_q)
      SW_STOP: begin
        if (!sw_mode) begin
          if (rise[0])      sw_state_d = SW_RUN;
          else if (rise[1]) sw_state_d = SW_CLEAR;
        end
      end
      SW_RUN:   if (!sw_mode && rise[0]) sw_state_d = SW_STOP;
      // Leaves CLEAR even in set mode so sw_clear never stretches past one cycle.
      SW_CLEAR: sw_state_d = SW_STOP;
      default:  sw_state_d = SW_STOP;
    endcase
    sw_run_d   = (sw_state_d == SW_RUN);
    sw_clear_d = (sw_state_d == SW_CLEAR);
  end

  always_comb begin
    set_state_d = set_state_q;
    owner_d     = owner_q;
    inc_d       = 3'b000;
`ifdef WATCH_AUTO_REPEAT_EN
    cnt_d       = cnt_q;
`endif
    if (!sw_mode) begin
      set_state_d = SET_IDLE;
      owner_d     = 3'b000;
`ifdef WATCH_AUTO_REPEAT_EN
      cnt_d       = '0;
`endif
    end else begin
      unique case (set_state_q)
        SET_IDLE: begin
          if (|set_rise) begin
            owner_d = pick;
            inc_d   = pick;
`ifdef WATCH_AUTO_REPEAT_EN
            cnt_d       = '0;
            set_state_d = SET_HOLD;
`else
            set_state_d = SET_WAIT_RELEASE;
`endif
          end
        end
`ifdef WATCH_AUTO_REPEAT_EN
        SET_HOLD, SET_REPEAT: begin
          if (!owner_held) begin
            set_state_d = SET_IDLE;
            owner_d     = 3'b000;
            cnt_d       = '0;
          end else if (cnt_q == ((set_state_q == SET_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
            inc_d       = owner_q;
            cnt_d       = '0;
            set_state_d = SET_REPEAT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`else
        SET_WAIT_RELEASE: begin
          if (!owner_held) begin
            set_state_d = SET_IDLE;
            owner_d     = 3'b000;
          end
        end
`endif
        default: begin
          set_state_d = SET_IDLE;
          owner_d     = 3'b000;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q      <= '0;
      sw_state_q  <= SW_STOP;
      sw_run_q    <= 1'b0;
      sw_clear_q  <= 1'b0;
      set_state_q <= SET_IDLE;
      owner_q     <= 3'b000;
      inc_q       <= 3'b000;
`ifdef WATCH_AUTO_REPEAT_EN
      cnt_q       <= '0;
`endif
    end else begin
      prev_q      <= btn_vec;
      sw_state_q  <= sw_state_d;
      sw_run_q    <= sw_run_d;
      sw_clear_q  <= sw_clear_d;
      set_state_q <= set_state_d;
      owner_q     <= owner_d;
      inc_q       <= inc_d;
`ifdef WATCH_AUTO_REPEAT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign sw_run   = sw_run_q;
  assign sw_clear = sw_clear_q;
  assign sw_state = sw_state_q;
  assign inc_sec  = inc_q[0];
  assign inc_min  = inc_q[1];
  assign inc_hour = inc_q[2];

endmodule
